// File: rtl/axil_ctrl_to_sb_pkg.sv
// rtl/axil_ctrl_to_sb_pkg.sv - shared state encoding and default widths for the ctrl-to-switchboard bridge
package axil_ctrl_to_sb_pkg;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_SEQ_WIDTH  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/axil_ctrl_capture.sv
// rtl/axil_ctrl_capture.sv - independent AW/W holding registers with full flags and ready logic
module axil_ctrl_capture
  import axil_ctrl_to_sb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  idle_i,
  input  logic                  clear_i,
  input  logic                  awvalid_i,
  input  logic [ADDR_WIDTH-1:0] awaddr_i,
  input  logic                  wvalid_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  awready_o,
  output logic                  wready_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  both_full_next_o
);

  logic                  aw_full_q, aw_full_d;
  logic                  w_full_q, w_full_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  aw_hs, w_hs;

  assign awready_o = idle_i && !aw_full_q;
  assign wready_o  = idle_i && !w_full_q;
  assign aw_hs     = awvalid_i && awready_o;
  assign w_hs      = wvalid_i && wready_o;

  always_comb begin
    aw_full_d = aw_full_q;
    w_full_d  = w_full_q;
    addr_d    = addr_q;
    data_d    = data_q;
    if (aw_hs) begin
      aw_full_d = 1'b1;
      addr_d    = awaddr_i;
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      data_d   = wdata_i;
    end
    // Clear only happens in SEND, where no handshake is possible
    if (clear_i) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
    end
  end

  assign both_full_next_o = aw_full_d && w_full_d;
  assign addr_o           = addr_q;
  assign data_o           = data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      aw_full_q <= aw_full_d;
      w_full_q  <= w_full_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
    end
  end

endmodule

// File: rtl/axil_ctrl_to_sb.sv
// rtl/axil_ctrl_to_sb.sv - non-posted AXI-lite write to switchboard packet bridge
module axil_ctrl_to_sb
  import axil_ctrl_to_sb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int SEQ_WIDTH  = DEF_SEQ_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ctrl_awvalid,
  output logic                  ctrl_awready,
  input  logic [ADDR_WIDTH-1:0] ctrl_awaddr,
  input  logic                  ctrl_wvalid,
  output logic                  ctrl_wready,
  input  logic [DATA_WIDTH-1:0] ctrl_wdata,
  output logic                  ctrl_bvalid,
  input  logic                  ctrl_bready,
  output logic                  sb_valid,
  input  logic                  sb_ready,
  output logic [ADDR_WIDTH-1:0] sb_addr,
  output logic [DATA_WIDTH-1:0] sb_data,
  output logic [SEQ_WIDTH-1:0]  sb_seq,
  output logic [31:0]           pkt_count
);

  state_e               state_q, state_d;
  logic [SEQ_WIDTH-1:0] seq_q, seq_d;
  logic [31:0]          cnt_q, cnt_d;
  logic                 clear;
  logic                 both_full_next;

  axil_ctrl_capture #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_capture (
    .clk              (clk),
    .rst              (rst),
    .idle_i           (state_q == ST_IDLE),
    .clear_i          (clear),
    .awvalid_i        (ctrl_awvalid),
    .awaddr_i         (ctrl_awaddr),
    .wvalid_i         (ctrl_wvalid),
    .wdata_i          (ctrl_wdata),
    .awready_o        (ctrl_awready),
    .wready_o         (ctrl_wready),
    .addr_o           (sb_addr),
    .data_o           (sb_data),
    .both_full_next_o (both_full_next)
  );

  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    cnt_d   = cnt_q;
    clear   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (both_full_next) state_d = ST_SEND;
      end
      ST_SEND: begin
        if (sb_ready) begin
          state_d = ST_RESP;
          seq_d   = seq_q + 1'b1;
          cnt_d   = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
          clear   = 1'b1;
        end
      end
      ST_RESP: begin
        if (ctrl_bready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs come straight from the state register
  assign sb_valid    = (state_q == ST_SEND);
  assign ctrl_bvalid = (state_q == ST_RESP);
  assign sb_seq      = seq_q;
  assign pkt_count   = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      seq_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_axil_ctrl_to_sb.sv
// tb/tb_axil_ctrl_to_sb.sv - scoreboard bench for the ctrl-to-switchboard bridge
module tb_axil_ctrl_to_sb;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [7:0]  s;
  } pkt_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ctrl_awvalid, ctrl_awready;
  logic [31:0] ctrl_awaddr;
  logic        ctrl_wvalid, ctrl_wready;
  logic [31:0] ctrl_wdata;
  logic        ctrl_bvalid, ctrl_bready;
  logic        sb_valid, sb_ready;
  logic [31:0] sb_addr, sb_data;
  logic [7:0]  sb_seq;
  logic [31:0] pkt_count;

  int   total = 0;
  int   bad = 0;
  pkt_t exp_q[$];
  pkt_t mp;
  logic [7:0] model_seq;

  always #5 clk = ~clk;

  axil_ctrl_to_sb dut (
    .clk          (clk),
    .rst          (rst),
    .ctrl_awvalid (ctrl_awvalid),
    .ctrl_awready (ctrl_awready),
    .ctrl_awaddr  (ctrl_awaddr),
    .ctrl_wvalid  (ctrl_wvalid),
    .ctrl_wready  (ctrl_wready),
    .ctrl_wdata   (ctrl_wdata),
    .ctrl_bvalid  (ctrl_bvalid),
    .ctrl_bready  (ctrl_bready),
    .sb_valid     (sb_valid),
    .sb_ready     (sb_ready),
    .sb_addr      (sb_addr),
    .sb_data      (sb_data),
    .sb_seq       (sb_seq),
    .pkt_count    (pkt_count)
  );

  always @(negedge clk) begin
    if (!rst && sb_valid && sb_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL pkt_unexpected got addr=%h data=%h seq=%0d, none expected", sb_addr, sb_data, sb_seq);
      end else begin
        mp = exp_q.pop_front();
        if ({sb_addr, sb_data, sb_seq} !== {mp.a, mp.d, mp.s}) begin
          bad++;
          $display("FAIL pkt_content got addr=%h data=%h seq=%0d, want addr=%h data=%h seq=%0d",
                   sb_addr, sb_data, sb_seq, mp.a, mp.d, mp.s);
        end
      end
    end
  end

  task automatic push_exp(input logic [31:0] a, input logic [31:0] d);
    pkt_t p;
    p.a = a;
    p.d = d;
    p.s = model_seq;
    exp_q.push_back(p);
    model_seq = model_seq + 8'd1;
  endtask

  task automatic offer(input logic [31:0] a, input logic [31:0] d);
    ctrl_awvalid = 1'b1;
    ctrl_awaddr  = a;
    ctrl_wvalid  = 1'b1;
    ctrl_wdata   = d;
    push_exp(a, d);
  endtask

  task automatic drop;
    ctrl_awvalid = 1'b0;
    ctrl_wvalid  = 1'b0;
  endtask

  task automatic wait_idle;
    int n = 0;
    @(negedge clk);
    while (!(ctrl_awready && ctrl_wready && !ctrl_bvalid && !sb_valid) && n < 30) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 30) begin
      bad++;
      $display("FAIL idle_timeout got state not idle after %0d cycles, want idle", n);
    end
  endtask

  task automatic do_reset;
    @(posedge clk); #1;
    rst = 1'b1;
    drop();
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    model_seq = 8'd0;
  endtask

  task automatic test_reset;
    ctrl_awaddr = '0; ctrl_wdata = '0;
    sb_ready = 1'b1; ctrl_bready = 1'b1;
    do_reset();
    @(negedge clk);
    total++;
    if ({sb_valid, ctrl_bvalid, ctrl_awready, ctrl_wready} !== 4'b0011) begin
      bad++;
      $display("FAIL reset_hs got v=%b b=%b awr=%b wr=%b, want 0 0 1 1", sb_valid, ctrl_bvalid, ctrl_awready, ctrl_wready);
    end
    total++;
    if ({pkt_count, sb_seq, sb_addr, sb_data} !== 104'd0) begin
      bad++;
      $display("FAIL reset_regs got cnt=%0d seq=%0d addr=%h data=%h, want all 0", pkt_count, sb_seq, sb_addr, sb_data);
    end
  endtask

  task automatic test_same_cycle;
    sb_ready = 1'b1; ctrl_bready = 1'b1;
    @(posedge clk); #1;
    offer(32'h0002_0000, 32'hDEAD_BEEF);
    @(negedge clk);
    @(posedge clk); #1;
    drop();
    @(negedge clk);
    total++;
    if (sb_valid !== 1'b1) begin
      bad++;
      $display("FAIL same_latency got sb_valid=%b, want 1", sb_valid);
    end
    @(negedge clk);
    total++;
    if ({ctrl_bvalid, sb_valid, pkt_count} !== {2'b10, 32'd1}) begin
      bad++;
      $display("FAIL same_resp got b=%b v=%b cnt=%0d, want 1 0 1", ctrl_bvalid, sb_valid, pkt_count);
    end
    @(negedge clk);
    total++;
    if ({ctrl_bvalid, ctrl_awready, ctrl_wready} !== 3'b011) begin
      bad++;
      $display("FAIL same_back_idle got b=%b awr=%b wr=%b, want 0 1 1", ctrl_bvalid, ctrl_awready, ctrl_wready);
    end
  endtask

  task automatic test_w_before_aw;
    sb_ready = 1'b1; ctrl_bready = 1'b1;
    @(posedge clk); #1;
    ctrl_wvalid = 1'b1; ctrl_wdata = 32'h11;
    @(posedge clk); #1;
    ctrl_wvalid = 1'b0; ctrl_wdata = 32'h99;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if ({ctrl_wready, ctrl_awready, sb_valid} !== 3'b010) begin
        bad++;
        $display("FAIL wfirst_wait%0d got wr=%b awr=%b v=%b, want 0 1 0", k, ctrl_wready, ctrl_awready, sb_valid);
      end
      @(posedge clk); #1;
    end
    ctrl_awvalid = 1'b1; ctrl_awaddr = 32'h4000_0000;
    push_exp(32'h4000_0000, 32'h11);
    @(posedge clk); #1;
    ctrl_awvalid = 1'b0;
    @(negedge clk);
    total++;
    if (sb_valid !== 1'b1) begin
      bad++;
      $display("FAIL wfirst_send got sb_valid=%b, want 1", sb_valid);
    end
    wait_idle();
  endtask

  task automatic test_backpressure;
    logic [7:0] s;
    sb_ready = 1'b0; ctrl_bready = 1'b1;
    s = model_seq;
    @(posedge clk); #1;
    offer(32'hA5A5_0000, 32'h1234_5678);
    @(posedge clk); #1;
    drop();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      total++;
      if ({sb_valid, sb_addr, sb_data, sb_seq, ctrl_awready, ctrl_wready, ctrl_bvalid} !==
          {1'b1, 32'hA5A5_0000, 32'h1234_5678, s, 3'b000}) begin
        bad++;
        $display("FAIL bp_stable%0d got v=%b a=%h d=%h s=%0d awr=%b wr=%b b=%b, want 1 a5a50000 12345678 %0d 0 0 0",
                 k, sb_valid, sb_addr, sb_data, sb_seq, ctrl_awready, ctrl_wready, ctrl_bvalid, s);
      end
      @(posedge clk); #1;
      if (k < 9) begin
        ctrl_awvalid = 1'($urandom_range(0, 1));
        ctrl_wvalid  = 1'($urandom_range(0, 1));
        ctrl_awaddr  = $urandom;
        ctrl_wdata   = $urandom;
      end else begin
        drop();
        sb_ready = 1'b1;
      end
    end
    wait_idle();
  endtask

  task automatic test_back_to_back;
    sb_ready = 1'b1; ctrl_bready = 1'b1;
    do_reset();
    for (int i = 0; i < 257; i++) begin
      @(posedge clk); #1;
      offer(32'(i * 4), ~32'(i));
      @(negedge clk);
      if (!(ctrl_awready && ctrl_wready)) begin
        total++;
        bad++;
        $display("FAIL b2b_ready%0d got awr=%b wr=%b, want 1 1", i, ctrl_awready, ctrl_wready);
      end
      @(posedge clk); #1;
      drop();
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      if (ctrl_bvalid !== 1'b1) begin
        total++;
        bad++;
        $display("FAIL b2b_resp%0d got bvalid=%b, want 1", i, ctrl_bvalid);
      end
    end
    total++;
    wait_idle();
    total++;
    if (pkt_count !== 32'd257) begin
      bad++;
      $display("FAIL b2b_count got %0d, want 257", pkt_count);
    end
  endtask

  task automatic test_reset_mid;
    sb_ready = 1'b0; ctrl_bready = 1'b1;
    @(posedge clk); #1;
    offer(32'hCAFE_0000, 32'h0BAD_F00D);
    @(posedge clk); #1;
    drop();
    @(negedge clk);
    total++;
    if (sb_valid !== 1'b1) begin
      bad++;
      $display("FAIL rmid_send got sb_valid=%b, want 1", sb_valid);
    end
    do_reset();
    @(negedge clk);
    total++;
    if ({sb_valid, ctrl_bvalid, ctrl_awready, ctrl_wready, pkt_count} !== {4'b0011, 32'd0}) begin
      bad++;
      $display("FAIL rmid_after got v=%b b=%b awr=%b wr=%b cnt=%0d, want 0 0 1 1 0",
               sb_valid, ctrl_bvalid, ctrl_awready, ctrl_wready, pkt_count);
    end
    sb_ready = 1'b1;
    @(posedge clk); #1;
    offer(32'h0000_0100, 32'h0000_0200);
    @(posedge clk); #1;
    drop();
    wait_idle();
    total++;
    if (pkt_count !== 32'd1) begin
      bad++;
      $display("FAIL rmid_count got %0d, want 1", pkt_count);
    end
  endtask

  task automatic test_bready_stall;
    int n = 0;
    sb_ready = 1'b1; ctrl_bready = 1'b0;
    @(posedge clk); #1;
    offer(32'h0000_3000, 32'h3333_3333);
    @(posedge clk); #1;
    drop();
    @(negedge clk);
    while (!ctrl_bvalid && n < 10) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 10) begin
      bad++;
      $display("FAIL bstall_enter got no bvalid in %0d cycles, want bvalid", n);
    end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (k == 0) offer(32'h0000_7000, 32'h5555_5555);
      @(negedge clk);
      total++;
      if ({ctrl_bvalid, ctrl_awready, ctrl_wready} !== 3'b100) begin
        bad++;
        $display("FAIL bstall_hold%0d got b=%b awr=%b wr=%b, want 1 0 0", k, ctrl_bvalid, ctrl_awready, ctrl_wready);
      end
    end
    @(posedge clk); #1;
    ctrl_bready = 1'b1;
    @(negedge clk);
    total++;
    if ({ctrl_bvalid, ctrl_awready, ctrl_wready} !== 3'b100) begin
      bad++;
      $display("FAIL bstall_hs got b=%b awr=%b wr=%b, want 1 0 0", ctrl_bvalid, ctrl_awready, ctrl_wready);
    end
    @(negedge clk);
    total++;
    if ({ctrl_bvalid, ctrl_awready, ctrl_wready} !== 3'b011) begin
      bad++;
      $display("FAIL bstall_accept got b=%b awr=%b wr=%b, want 0 1 1", ctrl_bvalid, ctrl_awready, ctrl_wready);
    end
    @(posedge clk); #1;
    drop();
    wait_idle();
  endtask

  initial begin
    rst = 1'b0;
    ctrl_awvalid = 1'b0; ctrl_wvalid = 1'b0;
    ctrl_awaddr = '0; ctrl_wdata = '0;
    sb_ready = 1'b0; ctrl_bready = 1'b0;
    model_seq = 8'd0;
    test_reset();
    test_same_cycle();
    test_w_before_aw();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_bready_stall();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover got %0d packets outstanding, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
